decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 61 ++++++
 rtl/decode_stage.sv | 242 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : decode_stage_if                                                 |
// | Purpose  : Bundles the instruction handshake, the status-flag write, the   |
// |            decoded-bundle handshake and the decoded fields of the decode   |
// |            stage into one interface.                                       |
// | Modports : master - instruction source / bundle consumer (drives in_valid, |
// |                     gvn_instr, flag_we, flag_in, out_ready)                |
// |            slave  - the decode stage itself                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface decode_stage_if #(
  parameter int IW  = 16,
  parameter int OPW = 4,
  parameter int RW  = 3,
  parameter int AW  = 8,
  parameter int FW  = 4
) ();
  localparam int SHW = IW - OPW - 3*RW;  // shamt width
  localparam int CW  = IW - OPW - 2*RW;  // const width

  // Instruction handshake
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  gvn_instr;
  // Status-register write
  logic           flag_we;
  logic [FW-1:0]  flag_in;
  // Decoded-bundle handshake
  logic           out_valid;
  logic           out_ready;
  // Decoded fields ("const" is a reserved word, hence const_fld)
  logic [OPW-1:0] opcode;
  logic [RW-1:0]  rd;
  logic [RW-1:0]  rs;
  logic [RW-1:0]  rt;
  logic [SHW-1:0] shamt;
  logic [CW-1:0]  const_fld;
  logic [AW-1:0]  adr;
  logic           w_en;
  logic           rt_sel;
  logic           w_en2;
  logic           rd_sel;
  logic           pc_sel;
  logic           illegal;
  // Current status register
  logic [FW-1:0]  sr;

  modport master (
    output in_valid, gvn_instr, flag_we, flag_in, out_ready,
    input  in_ready, out_valid, opcode, rd, rs, rt, shamt, const_fld, adr,
           w_en, rt_sel, w_en2, rd_sel, pc_sel, illegal, sr
  );

  modport slave (
    input  in_valid, gvn_instr, flag_we, flag_in, out_ready,
    output in_ready, out_valid, opcode, rd, rs, rt, shamt, const_fld, adr,
           w_en, rt_sel, w_en2, rd_sel, pc_sel, illegal, sr
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : decode_stage                                                    |
// | Purpose  : One-cycle instruction decode stage with valid/ready handshakes, |
// |            a status register with same-cycle write bypass for conditional |
// |            jumps, and squashing of SQ instructions after a taken jump.     |
// | Ports    : clk - rising-edge clock                                         |
// |            rst - asynchronous active-low reset                             |
// |            bus - decode_stage_if.slave (handshakes, flags, decoded fields) |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module decode_stage #(
  parameter int IW  = 16,
  parameter int OPW = 4,
  parameter int RW  = 3,
  parameter int AW  = 8,
  parameter int FW  = 4,
  parameter int SQ  = 1
) (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus
);

  localparam int SHW = IW - OPW - 3*RW;
  localparam int CW  = IW - OPW - 2*RW;
  localparam int SQW = (SQ > 0) ? $clog2(SQ + 1) : 1;

  localparam logic [OPW-1:0] c_op_rlast = OPW'(4);
  localparam logic [OPW-1:0] c_op_i0    = OPW'(5);
  localparam logic [OPW-1:0] c_op_i1    = OPW'(6);
  localparam logic [OPW-1:0] c_op_ld    = OPW'(7);
  localparam logic [OPW-1:0] c_op_st    = OPW'(8);
  localparam logic [OPW-1:0] c_op_jmp   = OPW'(9);
  localparam logic [OPW-1:0] c_op_cj    = OPW'(14);
  localparam logic [SQW-1:0] c_sq       = SQW'(SQ);
  localparam logic [SQW-1:0] c_sq_one   = SQW'(1);
  localparam bit             c_sq_en    = (SQ > 0);

  // Reject parameter sets whose fields do not fit in the instruction word.
  if (IW < OPW + 3*RW + 1 || IW < OPW + AW + FW) begin : g_param_check
    $error("decode_stage: IW=%0d too small for OPW/RW/AW/FW fields", IW);
  end

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  logic [OPW-1:0] w_op;
  logic [RW-1:0]  w_rd, w_rs, w_rt;
  logic [SHW-1:0] w_shamt;
  logic [CW-1:0]  w_const;
  logic [AW-1:0]  w_adr;
  logic [FW-1:0]  w_mask;

  assign w_op    = bus.gvn_instr[OPW-1:0];
  assign w_rd    = bus.gvn_instr[OPW+RW-1:OPW];
  assign w_rs    = bus.gvn_instr[OPW+2*RW-1:OPW+RW];
  assign w_rt    = bus.gvn_instr[OPW+3*RW-1:OPW+2*RW];
  assign w_shamt = bus.gvn_instr[IW-1:OPW+3*RW];
  assign w_const = bus.gvn_instr[IW-1:OPW+2*RW];
  assign w_adr   = bus.gvn_instr[OPW+AW-1:OPW];
  assign w_mask  = bus.gvn_instr[OPW+AW+FW-1:OPW+AW];

  // ---------------------------------------------------------------------------
  // Conditional-jump evaluation; a flag write in the same cycle is bypassed
  // so the branch sees the value the status register is about to take.
  // An all-zero mask means "any flag set".
  // ---------------------------------------------------------------------------
  logic [FW-1:0] r_sr;
  logic [FW-1:0] w_s;
  logic          w_taken;

  assign w_s     = bus.flag_we ? bus.flag_in : r_sr;
  assign w_taken = (w_mask == '0) ? (|w_s) : (|(w_s & w_mask));

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  logic w_wen, w_rtsel, w_wen2, w_rdsel, w_pcsel, w_ill;
  logic w_is_rtype;

  assign w_is_rtype = (w_op <= c_op_rlast);

  always_comb begin
    w_wen   = 1'b0;
    w_rtsel = 1'b0;
    w_wen2  = 1'b0;
    w_rdsel = 1'b0;
    w_pcsel = 1'b0;
    w_ill   = 1'b0;
    if (w_is_rtype) begin
      w_wen = 1'b1;
    end else if (w_op == c_op_i0 || w_op == c_op_i1) begin
      w_rtsel = 1'b1;
      w_wen   = 1'b1;
    end else if (w_op == c_op_ld) begin
      w_rtsel = 1'b1;
      w_rdsel = 1'b1;
      w_wen   = 1'b1;
    end else if (w_op == c_op_st) begin
      w_rtsel = 1'b1;
      w_wen2  = 1'b1;
    end else if (w_op == c_op_jmp) begin
      w_pcsel = 1'b1;
    end else if (w_op == c_op_cj) begin
      w_pcsel = w_taken;
    end else begin
      w_ill = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic r_out_valid;
  logic w_in_ready;
  logic w_xfer;
  logic w_squash;
  logic w_accept;
  logic w_redirect;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_xfer     = bus.in_valid && w_in_ready;
  assign w_redirect = (w_op == c_op_jmp) || ((w_op == c_op_cj) && w_taken);

  // ---------------------------------------------------------------------------
  // Squash state machine
  // ---------------------------------------------------------------------------
  state_t         r_state, w_state_nxt;
  logic [SQW-1:0] r_sq_cnt, w_sq_cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_sq_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sq_cnt <= w_sq_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sq_cnt_nxt = r_sq_cnt;
    w_squash     = 1'b0;
    if (r_state == ST_RUN) begin
      if (c_sq_en && w_xfer && w_redirect) begin
        w_state_nxt  = ST_SQUASH;
        w_sq_cnt_nxt = c_sq;
      end
    end else begin
      // Everything arriving here is dropped, jumps included, so a jump in
      // the shadow of another never restarts the count.
      w_squash = 1'b1;
      if (w_xfer) begin
        w_sq_cnt_nxt = r_sq_cnt - c_sq_one;
        if (r_sq_cnt <= c_sq_one) begin
          w_state_nxt = ST_RUN;
        end
      end
    end
  end

  assign w_accept = w_xfer && !w_squash;

  // ---------------------------------------------------------------------------
  // Output bundle and status register
  // ---------------------------------------------------------------------------
  logic [OPW-1:0] r_opcode;
  logic [RW-1:0]  r_rd, r_rs, r_rt;
  logic [SHW-1:0] r_shamt;
  logic [CW-1:0]  r_const;
  logic [AW-1:0]  r_adr;
  logic           r_wen, r_rtsel, r_wen2, r_rdsel, r_pcsel, r_ill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_sr        <= '0;
      r_opcode    <= '0;
      r_rd        <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_shamt     <= '0;
      r_const     <= '0;
      r_adr       <= '0;
      r_wen       <= 1'b0;
      r_rtsel     <= 1'b0;
      r_wen2      <= 1'b0;
      r_rdsel     <= 1'b0;
      r_pcsel     <= 1'b0;
      r_ill       <= 1'b0;
    end else begin
      if (bus.flag_we) begin
        r_sr <= bus.flag_in;
      end
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_opcode    <= w_op;
        r_rd        <= w_rd;
        r_rs        <= w_rs;
        r_rt        <= w_rt;
        r_shamt     <= w_shamt;
        r_const     <= w_is_rtype ? '0 : w_const;
        r_adr       <= w_adr;
        r_wen       <= w_wen;
        r_rtsel     <= w_rtsel;
        r_wen2      <= w_wen2;
        r_rdsel     <= w_rdsel;
        r_pcsel     <= w_pcsel;
        r_ill       <= w_ill;
      end else if (bus.out_ready) begin
        // Also covers a squashed transfer: the consumer took the old bundle.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.opcode    = r_opcode;
  assign bus.rd        = r_rd;
  assign bus.rs        = r_rs;
  assign bus.rt        = r_rt;
  assign bus.shamt     = r_shamt;
  assign bus.const_fld = r_const;
  assign bus.adr       = r_adr;
  assign bus.w_en      = r_wen;
  assign bus.rt_sel    = r_rtsel;
  assign bus.w_en2     = r_wen2;
  assign bus.rd_sel    = r_rdsel;
  assign bus.pc_sel    = r_pcsel;
  assign bus.illegal   = r_ill;
  assign bus.sr        = r_sr;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_decode_stage                                                 |
// | Purpose  : Directed-vector self-checking bench for decode_stage (SQ=1).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_decode_stage;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  decode_stage_if #(.IW(16), .OPW(4), .RW(3), .AW(8), .FW(4)) bus ();

  decode_stage #(
    .IW (16),
    .OPW(4),
    .RW (3),
    .AW (8),
    .FW (4),
    .SQ (1)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Control bits packed as {w_en, rt_sel, w_en2, rd_sel, pc_sel, illegal}
  function automatic logic [31:0] ctl();
    return 32'({bus.w_en, bus.rt_sel, bus.w_en2, bus.rd_sel, bus.pc_sel, bus.illegal});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.gvn_instr = '0;
    bus.flag_we   = 1'b0;
    bus.flag_in   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #2;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("rst_sr",        32'(bus.sr),        32'd0);
    check_eq("rst_ctl",       ctl(),              32'd0);
    check_eq("rst_opcode",    32'(bus.opcode),    32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // I-type decode 0x1235
    bus.in_valid = 1'b1; bus.gvn_instr = 16'h1235;
    tick();
    bus.in_valid = 1'b0;
    check_eq("dec_out_valid", 32'(bus.out_valid), 32'd1);
    check_eq("dec_ctl",       ctl(),              32'b110000);
    check_eq("dec_opcode",    32'(bus.opcode),    32'd5);
    check_eq("dec_rd",        32'(bus.rd),        32'd3);
    check_eq("dec_rs",        32'(bus.rs),        32'd4);
    check_eq("dec_rt",        32'(bus.rt),        32'd4);
    check_eq("dec_const",     32'(bus.const_fld), 32'h04);
    check_eq("dec_adr",       32'(bus.adr),       32'h23);
    tick();
    check_eq("dec_clear",     32'(bus.out_valid), 32'd0);

    // R-type forces const to zero
    bus.in_valid = 1'b1; bus.gvn_instr = 16'hFC01;
    tick();
    bus.in_valid = 1'b0;
    check_eq("r_ctl",   ctl(),              32'b100000);
    check_eq("r_const", 32'(bus.const_fld), 32'd0);
    check_eq("r_shamt", 32'(bus.shamt),     32'd7);
    check_eq("r_rt",    32'(bus.rt),        32'd7);
    tick();

    // Backpressure: load held for 3 cycles, store follows
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.gvn_instr = 16'h0007;
    tick();
    bus.gvn_instr = 16'h0008;
    check_eq("bp_valid1",  32'(bus.out_valid), 32'd1);
    check_eq("bp_ready1",  32'(bus.in_ready),  32'd0);
    check_eq("bp_ld_ctl",  ctl(),              32'b110100);
    tick();
    check_eq("bp_hold2_op", 32'(bus.opcode),   32'd7);
    check_eq("bp_ready2",   32'(bus.in_ready), 32'd0);
    tick();
    check_eq("bp_hold3_op",  32'(bus.opcode), 32'd7);
    check_eq("bp_hold3_ctl", ctl(),           32'b110100);
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_ready_rel", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check_eq("bp_st_valid", 32'(bus.out_valid), 32'd1);
    check_eq("bp_st_op",    32'(bus.opcode),    32'd8);
    check_eq("bp_st_ctl",   ctl(),              32'b011000);
    tick();
    check_eq("bp_clear", 32'(bus.out_valid), 32'd0);

    // Jump squash
    bus.in_valid = 1'b1; bus.gvn_instr = 16'h0A59;
    tick();
    check_eq("j_valid", 32'(bus.out_valid), 32'd1);
    check_eq("j_ctl",   ctl(),              32'b000010);
    check_eq("j_adr",   32'(bus.adr),       32'hA5);
    bus.gvn_instr = 16'h0000;
    tick();
    check_eq("j_squash_valid", 32'(bus.out_valid), 32'd0);
    check_eq("j_squash_hold",  32'(bus.opcode),    32'd9);
    bus.gvn_instr = 16'h0010;
    tick();
    check_eq("j_next_valid", 32'(bus.out_valid), 32'd1);
    check_eq("j_next_rd",    32'(bus.rd),        32'd1);
    check_eq("j_next_op",    32'(bus.opcode),    32'd0);
    bus.in_valid = 1'b0;
    tick();

    // Conditional jump taken through the flag bypass
    bus.flag_we = 1'b1; bus.flag_in = 4'b0100;
    bus.in_valid = 1'b1; bus.gvn_instr = 16'h400E;
    tick();
    bus.flag_we = 1'b0;
    check_eq("cj_byp_ctl", ctl(),         32'b000010);
    check_eq("cj_byp_sr",  32'(bus.sr),   32'b0100);
    bus.gvn_instr = 16'h0010;
    tick();
    check_eq("cj_squash", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    bus.flag_we = 1'b1; bus.flag_in = 4'b0010;
    tick();
    bus.flag_we = 1'b0;
    check_eq("cj_sr_wr", 32'(bus.sr), 32'b0010);
    // Not taken: sr=0010, mask=0100
    bus.in_valid = 1'b1; bus.gvn_instr = 16'h400E;
    tick();
    check_eq("cj_nt_valid", 32'(bus.out_valid), 32'd1);
    check_eq("cj_nt_ctl",   ctl(),              32'd0);
    check_eq("cj_nt_const", 32'(bus.const_fld), 32'h10);
    bus.gvn_instr = 16'h0020;
    tick();
    check_eq("cj_nt_next_valid", 32'(bus.out_valid), 32'd1);
    check_eq("cj_nt_next_rd",    32'(bus.rd),        32'd2);
    // Zero mask: taken on any flag set
    bus.gvn_instr = 16'h000E;
    tick();
    check_eq("cj_m0_ctl", ctl(), 32'b000010);
    bus.gvn_instr = 16'h0030;
    tick();
    check_eq("cj_m0_squash", 32'(bus.out_valid), 32'd0);

    // Illegal opcode
    bus.gvn_instr = 16'h000B;
    tick();
    bus.in_valid = 1'b0;
    check_eq("ill_valid", 32'(bus.out_valid), 32'd1);
    check_eq("ill_ctl",   ctl(),              32'b000001);
    check_eq("ill_op",    32'(bus.opcode),    32'hB);
    tick();

    // Asynchronous reset while in SQUASH
    bus.in_valid = 1'b1; bus.gvn_instr = 16'h0A59;
    tick();
    bus.in_valid = 1'b0;
    check_eq("mr_jump_ctl", ctl(), 32'b000010);
    #1;
    rst = 1'b0;
    #1;
    check_eq("mr_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mr_in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("mr_sr",        32'(bus.sr),        32'd0);
    check_eq("mr_ctl",       ctl(),              32'd0);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.gvn_instr = 16'h0010;
    tick();
    bus.in_valid = 1'b0;
    check_eq("mr_next_valid", 32'(bus.out_valid), 32'd1);
    check_eq("mr_next_rd",    32'(bus.rd),        32'd1);
    check_eq("mr_next_ctl",   ctl(),              32'b100000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
